// File: rtl/zeroriscy_irq_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : zeroriscy_irq_arbiter_if
// Brief    : Interrupt lines, core irq/ack handshake and config register port.
// Revision : 1.0
// ============================================================================
interface zeroriscy_irq_arbiter_if #(
    parameter int N_IRQ = 32
);
    logic [N_IRQ-1:0] irq_src_i;
    logic             irq_o;
    logic [4:0]       irq_id_o;
    logic             irq_ack_i;
    logic             cfg_we_i;
    logic [1:0]       cfg_addr_i;
    logic [31:0]      cfg_wdata_i;
    logic [31:0]      cfg_rdata_o;

    modport slave (
        input  irq_src_i, irq_ack_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
        output irq_o, irq_id_o, cfg_rdata_o
    );

    modport master (
        output irq_src_i, irq_ack_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
        input  irq_o, irq_id_o, cfg_rdata_o
    );
endinterface
`default_nettype wire

// File: rtl/zeroriscy_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : zeroriscy_irq_arbiter
// Brief    : Pending/enable interrupt collector with fixed or round-robin
//            arbitration feeding a single irq/id request to the core.
// Revision : 1.0
// ============================================================================
module zeroriscy_irq_arbiter #(
    parameter int          N_IRQ       = 32,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] EDGE_MASK   = 32'h0,
    parameter bit          RR_EN       = 1'b0
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    zeroriscy_irq_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [N_IRQ-1:0] c_EDGE = EDGE_MASK[N_IRQ-1:0];

    logic [N_IRQ-1:0] w_synced;
    logic [N_IRQ-1:0] r_prev;
    logic [N_IRQ-1:0] r_en;
    logic [N_IRQ-1:0] r_pend;
    logic [N_IRQ-1:0] w_elig;
    logic [N_IRQ-1:0] w_set;
    logic [N_IRQ-1:0] w_clr;
    logic [N_IRQ-1:0] w_idmask;
    logic [N_IRQ-1:0] w_wdata;
    state_t           r_state;
    logic             r_irq;
    logic [4:0]       r_id;
    logic [4:0]       r_last;
    logic [4:0]       w_winner;
    logic [4:0]       w_lo;
    logic [4:0]       w_hi;
    logic             w_hi_found;
    logic             w_any;
    logic             w_held_elig;
    logic             w_ack;
    logic             w_wr_en;
    logic             w_wr_pend;
    logic             w_wr_set;
    logic [31:0]      w_rdata;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [N_IRQ-1:0] r_sync [SYNC_STAGES];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < SYNC_STAGES; s++) begin
                        r_sync[s] <= '0;
                    end
                end else begin
                    r_sync[0] <= bus.irq_src_i;
                    for (int s = 1; s < SYNC_STAGES; s++) begin
                        r_sync[s] <= r_sync[s-1];
                    end
                end
            end

            assign w_synced = r_sync[SYNC_STAGES-1];
        end else begin : g_bypass
            assign w_synced = bus.irq_src_i;
        end
    endgenerate

    assign w_wdata   = bus.cfg_wdata_i[N_IRQ-1:0];
    assign w_wr_en   = bus.cfg_we_i && (bus.cfg_addr_i == 2'd0);
    assign w_wr_pend = bus.cfg_we_i && (bus.cfg_addr_i == 2'd1);
    assign w_wr_set  = bus.cfg_we_i && (bus.cfg_addr_i == 2'd2);
    assign w_ack     = (r_state == S_REQ) && bus.irq_ack_i;
    assign w_elig    = r_en & r_pend;
    assign w_any     = |w_elig;

    always_comb begin
        w_idmask = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            w_idmask[i] = (r_id == 5'(i));
        end
    end

    assign w_held_elig = |(w_elig & w_idmask);

    // Set dominates clear, so a level source still asserted survives its own ack.
    assign w_set = (~c_EDGE & w_synced)
                 | (c_EDGE & w_synced & ~r_prev)
                 | (w_wr_set ? w_wdata : '0);
    assign w_clr = (w_wr_pend ? w_wdata : '0)
                 | (w_ack ? w_idmask : '0);

    // Round-robin picks the lowest eligible index above the last grant, else wraps.
    always_comb begin
        w_lo       = '0;
        w_hi       = '0;
        w_hi_found = 1'b0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_lo = 5'(i);
                if (5'(i) > r_last) begin
                    w_hi       = 5'(i);
                    w_hi_found = 1'b1;
                end
            end
        end
        w_winner = (RR_EN && w_hi_found) ? w_hi : w_lo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en   <= '0;
            r_pend <= '0;
            r_prev <= '0;
        end else begin
            if (w_wr_en) begin
                r_en <= w_wdata;
            end
            r_pend <= (r_pend & ~w_clr) | w_set;
            r_prev <= w_synced;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_irq   <= 1'b0;
            r_id    <= '0;
            r_last  <= 5'(N_IRQ - 1);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_id    <= w_winner;
                        r_irq   <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.irq_ack_i) begin
                        r_last  <= r_id;
                        r_irq   <= 1'b0;
                        r_state <= S_GAP;
                    end else if (!w_held_elig) begin
                        r_irq   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_GAP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_irq   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_rdata = '0;
        case (bus.cfg_addr_i)
            2'd0:    w_rdata = 32'(r_en);
            2'd1:    w_rdata = 32'(r_pend);
            2'd2:    w_rdata = '0;
            default: w_rdata = {r_irq, 21'b0, r_state, 3'b0, r_id};
        endcase
    end

    assign bus.irq_o       = r_irq;
    assign bus.irq_id_o    = r_id;
    assign bus.cfg_rdata_o = w_rdata;

endmodule
`default_nettype wire

// File: tb/tb_zeroriscy_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_zeroriscy_irq_arbiter
// Brief    : Directed scoreboard bench for the interrupt arbiter (fixed + RR).
// Revision : 1.0
// ============================================================================
module tb_zeroriscy_irq_arbiter;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] src;
    logic        ack;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        sel;
    logic        rd_chk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_grant  = 0;
    int g_tgt    = 0;

    exp_t       q_rd[$];
    logic [4:0] q_id[$];

    always #5 clk = ~clk;

    zeroriscy_irq_arbiter_if #(.N_IRQ(32)) if_a ();
    zeroriscy_irq_arbiter_if #(.N_IRQ(32)) if_b ();

    assign if_a.irq_src_i   = src;
    assign if_a.irq_ack_i   = ack;
    assign if_a.cfg_we_i    = we;
    assign if_a.cfg_addr_i  = addr;
    assign if_a.cfg_wdata_i = wdata;
    assign if_b.irq_src_i   = src;
    assign if_b.irq_ack_i   = ack;
    assign if_b.cfg_we_i    = we;
    assign if_b.cfg_addr_i  = addr;
    assign if_b.cfg_wdata_i = wdata;

    // Fixed priority, source 0 edge-triggered.
    zeroriscy_irq_arbiter #(
        .N_IRQ(32), .SYNC_STAGES(2), .EDGE_MASK(32'h1), .RR_EN(1'b0)
    ) u_dut_fp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a)
    );

    // Round-robin, all sources level.
    zeroriscy_irq_arbiter #(
        .N_IRQ(32), .SYNC_STAGES(2), .EDGE_MASK(32'h0), .RR_EN(1'b1)
    ) u_dut_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Monitor: pops reads when strobed and grants on each irq rising edge.
    initial begin : monitor
        logic       prev_irq;
        logic       cur_irq;
        logic [4:0] cur_id;
        logic [31:0] cur_rd;
        exp_t       e;
        logic [4:0] eid;
        prev_irq = 1'b0;
        forever begin
            @(negedge clk);
            cur_irq = sel ? if_b.irq_o       : if_a.irq_o;
            cur_id  = sel ? if_b.irq_id_o    : if_a.irq_id_o;
            cur_rd  = sel ? if_b.cfg_rdata_o : if_a.cfg_rdata_o;
            if (rd_chk) begin
                if (q_rd.size() == 0) begin
                    check("read_without_expectation", 32'h1, 32'h0);
                end else begin
                    e = q_rd.pop_front();
                    check(e.name, cur_rd, e.val);
                end
            end
            if (cur_irq && !prev_irq) begin
                n_grant++;
                if (q_id.size() == 0) begin
                    check("unexpected_grant_id", 32'(cur_id), 32'hFFFF_FFFF);
                end else begin
                    eid = q_id.pop_front();
                    check("grant_id", 32'(cur_id), 32'(eid));
                end
            end
            prev_irq = cur_irq;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        we    = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        we    = 1'b0;
    endtask

    task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.val  = exp;
        q_rd.push_back(e);
        addr   = a;
        rd_chk = 1'b1;
        tick();
        rd_chk = 1'b0;
    endtask

    task automatic wait_next();
        g_tgt++;
        for (int c = 0; c < 40 && n_grant < g_tgt; c++) begin
            @(negedge clk);
            #1;
        end
        if (n_grant < g_tgt) begin
            n_checks++;
            n_fail++;
            $display("FAIL grant_timeout: got %0d grants expected %0d", n_grant, g_tgt);
        end
        tick();
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        src    = '0;
        ack    = 1'b0;
        we     = 1'b0;
        addr   = '0;
        wdata  = '0;
        sel    = 1'b0;
        rd_chk = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        rd("reset_enable",  2'd0, 32'h0);
        rd("reset_pending", 2'd1, 32'h0);
        rd("reset_status",  2'd3, 32'h0);

        // Edge source 0, single-cycle pulse.
        wr(2'd0, 32'h1);
        q_id.push_back(5'd0);
        src[0] = 1'b1;
        tick();
        src[0] = 1'b0;
        wait_next();
        do_ack();
        rd("t1_status_gap", 2'd3, 32'h0000_0200);
        rd("t1_pending",    2'd1, 32'h0);
        rd("t1_status_idle", 2'd3, 32'h0);

        // Fixed priority among software-set bits 4 and 7.
        wr(2'd0, 32'hFFFF_FFFF);
        q_id.push_back(5'd4);
        q_id.push_back(5'd7);
        wr(2'd2, 32'h0000_0090);
        wait_next();
        do_ack();
        wait_next();
        do_ack();
        rd("t2_pending", 2'd1, 32'h0);

        // Disabling the held id withdraws the request without switching id.
        q_id.push_back(5'd5);
        wr(2'd2, 32'h0000_0020);
        wait_next();
        wr(2'd0, 32'hFFFF_FFDF);
        rd("t4_status_still_req", 2'd3, 32'h8000_0105);
        rd("t4_status_idle",      2'd3, 32'h0000_0005);
        rd("t4_pending_kept",     2'd1, 32'h0000_0020);
        rd("t4_set_reads_zero",   2'd2, 32'h0);
        wr(2'd1, 32'h0000_0020);
        wr(2'd0, 32'hFFFF_FFFF);
        rd("t4_pending_w1c", 2'd1, 32'h0);

        // Software set of id 3 in the same cycle as its ack.
        q_id.push_back(5'd3);
        q_id.push_back(5'd3);
        wr(2'd2, 32'h0000_0008);
        wait_next();
        we    = 1'b1;
        addr  = 2'd2;
        wdata = 32'h0000_0008;
        ack   = 1'b1;
        tick();
        we    = 1'b0;
        ack   = 1'b0;
        rd("t5_pending_set_wins", 2'd1, 32'h0000_0008);
        wait_next();
        do_ack();
        rd("t5_pending_cleared", 2'd1, 32'h0);

        // Reset while a request is outstanding.
        q_id.push_back(5'd14);
        wr(2'd2, 32'h0000_4000);
        wait_next();
        rst_n = 1'b0;
        rd("t6_status_in_reset",  2'd3, 32'h0);
        rd("t6_pending_in_reset", 2'd1, 32'h0);
        rd("t6_enable_in_reset",  2'd0, 32'h0);
        rst_n = 1'b1;
        do_ack();
        rd("t6_status_after_ack",  2'd3, 32'h0);
        rd("t6_pending_after_ack", 2'd1, 32'h0);

        // Round-robin between level sources 2 and 9.
        sel = 1'b1;
        tick();
        wr(2'd0, 32'hFFFF_FFFF);
        q_id.push_back(5'd2);
        q_id.push_back(5'd9);
        q_id.push_back(5'd2);
        q_id.push_back(5'd9);
        src[2] = 1'b1;
        src[9] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_next();
            if (k == 3) begin
                src = '0;
            end
            do_ack();
        end
        wr(2'd0, 32'h0);
        repeat (4) tick();
        wr(2'd1, 32'hFFFF_FFFF);
        rd("t3_pending_clean", 2'd1, 32'h0);
        rd("t3_status_idle",   2'd3, 32'h0000_0009);
        repeat (3) tick();

        check("grant_queue_empty", 32'(q_id.size()), 32'h0);
        check("read_queue_empty",  32'(q_rd.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
